// File: rtl/bus_master_port_if.sv
// rtl/bus_master_port_if.sv - core request/response and bus-side signals of bus_master_port
// Signal suffixes are from the master's point of view; the slave modport is the core/bus side.
interface bus_master_port_if #(
  parameter int DWidth = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [DWidth-1:0] req_addr_i;
  logic              req_write_i;
  logic [DWidth-1:0] req_wdata_i;
  logic              rsp_valid_o;
  logic [DWidth-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic [DWidth-1:0] addr_o;
  logic              trans_o;
  logic              write_o;
  logic [DWidth-1:0] wdata_o;
  logic [DWidth-1:0] rdata_i;
  logic              resp_i;
  logic              ready_i;

  modport master (
    input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, rdata_i, resp_i, ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, addr_o, trans_o, write_o, wdata_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_write_i, req_wdata_i, rdata_i, resp_i, ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, addr_o, trans_o, write_o, wdata_o
  );
endinterface

// File: rtl/bus_master_port.sv
// rtl/bus_master_port.sv - pipelined bus master with overlapped address/data phases
// AP holds the request in address phase, DP the one in data phase; the FSM tracks the data phase.
module bus_master_port #(
  parameter int DWidth = 32
) (
  input logic              clk_i,
  input logic              rst_i,
  bus_master_port_if.master bus
);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StErr2
  } state_e;

  state_e            state_q, state_d;
  logic              ap_valid_q, ap_valid_d;
  logic [DWidth-1:0] ap_addr_q, ap_addr_d;
  logic              ap_write_q, ap_write_d;
  logic [DWidth-1:0] ap_wdata_q, ap_wdata_d;
  logic              dp_write_q, dp_write_d;
  logic [DWidth-1:0] dp_wdata_q, dp_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DWidth-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              ap_move;
  logic              accept;
  logic              complete;
  logic              complete_err;

  always_comb begin
    state_d      = state_q;
    ap_valid_d   = ap_valid_q;
    ap_addr_d    = ap_addr_q;
    ap_write_d   = ap_write_q;
    ap_wdata_d   = ap_wdata_q;
    dp_write_d   = dp_write_q;
    dp_wdata_d   = dp_wdata_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    complete     = 1'b0;
    complete_err = 1'b0;

    // An error response cancels the overlapped address phase; AP is kept for replay.
    ap_move = ap_valid_q & bus.ready_i & (state_q != StErr2)
            & !((state_q == StData) & bus.resp_i);
    accept  = bus.req_valid_i & (!ap_valid_q | ap_move);

    case (state_q)
      StIdle: begin
        if (ap_move) state_d = StData;
      end
      StData: begin
        if (bus.ready_i) begin
          complete     = 1'b1;
          complete_err = bus.resp_i;
          state_d      = ap_move ? StData : StIdle;
        end else if (bus.resp_i) begin
          state_d = StErr2;
        end
      end
      StErr2: begin
        if (bus.ready_i) begin
          complete     = 1'b1;
          complete_err = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (ap_move) begin
      dp_write_d = ap_write_q;
      dp_wdata_d = ap_wdata_q;
      ap_valid_d = 1'b0;
    end
    if (accept) begin
      ap_valid_d = 1'b1;
      ap_addr_d  = bus.req_addr_i;
      ap_write_d = bus.req_write_i;
      ap_wdata_d = bus.req_wdata_i;
    end

    if (complete) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = complete_err;
      rsp_rdata_d = dp_write_q ? '0 : bus.rdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      ap_valid_q  <= 1'b0;
      ap_addr_q   <= '0;
      ap_write_q  <= 1'b0;
      ap_wdata_q  <= '0;
      dp_write_q  <= 1'b0;
      dp_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ap_valid_q  <= ap_valid_d;
      ap_addr_q   <= ap_addr_d;
      ap_write_q  <= ap_write_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_write_q  <= dp_write_d;
      dp_wdata_q  <= dp_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready_o = !ap_valid_q | ap_move;
  assign bus.trans_o     = ap_valid_q & (state_q != StErr2);
  assign bus.addr_o      = ap_addr_q;
  assign bus.write_o     = ap_write_q;
  assign bus.wdata_o     = (state_q != StIdle) ? dp_wdata_q : '0;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_bus_master_port.sv
// tb/tb_bus_master_port.sv - scoreboard bench for bus_master_port
// Inputs change 1ns after the rising edge; responses are checked at the falling edge.
module tb_bus_master_port;
  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_acc = 0;
  exp_t sb[$];
  int   rsp_log[$];

  bus_master_port_if #(.DWidth(DW)) bif ();

  bus_master_port #(.DWidth(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic step();
    exp_t e;
    @(negedge clk);
    if (bif.rsp_valid_o === 1'b1) begin
      rsp_log.push_back(cyc);
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected got valid=1 exp valid=0 cyc=%0d", cyc);
      end else begin
        e = sb.pop_front();
        checks++;
        if (bif.rsp_rdata_o !== e.rdata) begin
          failures++;
          $display("FAIL rsp_rdata got %h exp %h cyc=%0d", bif.rsp_rdata_o, e.rdata, cyc);
        end
        checks++;
        if (bif.rsp_err_o !== e.err) begin
          failures++;
          $display("FAIL rsp_err got %b exp %b cyc=%0d", bif.rsp_err_o, e.err, cyc);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [DW-1:0] a, input logic w, input logic [DW-1:0] d,
                       input logic [DW-1:0] er, input logic ee);
    int   n = 0;
    exp_t e;
    bif.req_valid_i = 1'b1;
    bif.req_addr_i  = a;
    bif.req_write_i = w;
    bif.req_wdata_i = d;
    #1;
    while (bif.req_ready_o !== 1'b1 && n < 20) begin
      step();
      #1;
      n++;
    end
    checks++;
    if (bif.req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL issue_timeout got ready=%b exp 1 addr=%h", bif.req_ready_o, a);
    end else begin
      e.rdata = er;
      e.err   = ee;
      sb.push_back(e);
      step();
      last_acc = cyc;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    bif.req_valid_i = 1'b0;
    while (sb.size() != 0 && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got %0d pending exp 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    bif.req_valid_i = 1'b0;
    bif.req_addr_i  = '0;
    bif.req_write_i = 1'b0;
    bif.req_wdata_i = '0;
    bif.rdata_i     = '0;
    bif.resp_i      = 1'b0;
    bif.ready_i     = 1'b1;
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({bif.trans_o, bif.write_o, bif.rsp_valid_o, bif.rsp_err_o} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags got %b exp 0000",
               {bif.trans_o, bif.write_o, bif.rsp_valid_o, bif.rsp_err_o});
    end
    checks++;
    if ({bif.addr_o, bif.wdata_o, bif.rsp_rdata_o} !== 96'h0) begin
      failures++;
      $display("FAIL reset_data got %h exp 0", {bif.addr_o, bif.wdata_o, bif.rsp_rdata_o});
    end
    checks++;
    if (bif.req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_req_ready got %b exp 1", bif.req_ready_o);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
    checks++;
    if (bif.trans_o !== 1'b0 || bif.rsp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got trans=%b rsp=%b exp 0 0", bif.trans_o, bif.rsp_valid_o);
    end
  endtask

  task automatic test_single_read();
    rsp_log.delete();
    bif.ready_i = 1'b1;
    bif.rdata_i = 32'hDEAD_BEEF;
    issue(32'h0000_0010, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    bif.req_valid_i = 1'b0;
    checks++;
    if (bif.trans_o !== 1'b1 || bif.addr_o !== 32'h10 || bif.write_o !== 1'b0) begin
      failures++;
      $display("FAIL t1_addr_phase got trans=%b addr=%h wr=%b exp 1 10 0",
               bif.trans_o, bif.addr_o, bif.write_o);
    end
    step();
    checks++;
    if (bif.rsp_valid_o !== 1'b0 || bif.trans_o !== 1'b0) begin
      failures++;
      $display("FAIL t1_data_phase got rsp=%b trans=%b exp 0 0", bif.rsp_valid_o, bif.trans_o);
    end
    step();
    checks++;
    if (bif.rsp_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL t1_rsp_latency got %b exp 1", bif.rsp_valid_o);
    end
    drain("t1");
    checks++;
    if (rsp_log.size() != 1 || rsp_log[0] != last_acc + 2) begin
      failures++;
      $display("FAIL t1_rsp_cycle got n=%0d exp rsp at acc+2", rsp_log.size());
    end
  endtask

  task automatic test_back_to_back();
    int acc0 = 0;
    rsp_log.delete();
    bif.ready_i = 1'b1;
    bif.rdata_i = 32'h1357_9BDF;
    for (int i = 0; i < 4; i++) begin
      issue(32'(i * 4), 1'b1, 32'(i + 1), 32'h0, 1'b0);
      if (i == 0) acc0 = last_acc;
      checks++;
      if (bif.trans_o !== 1'b1 || bif.addr_o !== 32'(i * 4) || bif.write_o !== 1'b1) begin
        failures++;
        $display("FAIL t2_addr%0d got trans=%b addr=%h exp 1 %h", i, bif.trans_o, bif.addr_o, i * 4);
      end
      if (i > 0) begin
        checks++;
        if (bif.wdata_o !== 32'(i)) begin
          failures++;
          $display("FAIL t2_wdata%0d got %h exp %h", i, bif.wdata_o, i);
        end
      end
    end
    bif.req_valid_i = 1'b0;
    step();
    checks++;
    if (bif.wdata_o !== 32'd4 || bif.trans_o !== 1'b0) begin
      failures++;
      $display("FAIL t2_last_data got wdata=%h trans=%b exp 4 0", bif.wdata_o, bif.trans_o);
    end
    drain("t2");
    checks++;
    if (rsp_log.size() != 4 || rsp_log[0] != acc0 + 2 || rsp_log[3] - rsp_log[0] != 3) begin
      failures++;
      $display("FAIL t2_rsp_pulses got n=%0d exp 4 consecutive from acc+2", rsp_log.size());
    end
  endtask

  task automatic test_wait_states();
    exp_t e;
    rsp_log.delete();
    bif.ready_i = 1'b1;
    bif.rdata_i = 32'h0BAD_0BAD;
    issue(32'h20, 1'b0, 32'h11, 32'hCAFE_0001, 1'b0);
    bif.req_addr_i  = 32'h24;
    bif.req_write_i = 1'b1;
    bif.req_wdata_i = 32'h55;
    #1;
    checks++;
    if (bif.req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL t3_queue_ready got %b exp 1", bif.req_ready_o);
    end
    e.rdata = '0;
    e.err   = 1'b0;
    sb.push_back(e);
    step();
    bif.req_addr_i  = 32'h28;
    bif.req_write_i = 1'b0;
    bif.req_wdata_i = 32'h0;
    bif.ready_i     = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (bif.req_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL t3_wait_ready%0d got %b exp 0", k, bif.req_ready_o);
      end
      checks++;
      if (bif.trans_o !== 1'b1 || bif.addr_o !== 32'h24 || bif.wdata_o !== 32'h11) begin
        failures++;
        $display("FAIL t3_wait_hold%0d got trans=%b addr=%h wdata=%h exp 1 24 11",
                 k, bif.trans_o, bif.addr_o, bif.wdata_o);
      end
      step();
    end
    checks++;
    if (rsp_log.size() != 0) begin
      failures++;
      $display("FAIL t3_rsp_during_wait got %0d exp 0", rsp_log.size());
    end
    bif.ready_i = 1'b1;
    bif.rdata_i = 32'hCAFE_0001;
    #1;
    checks++;
    if (bif.req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL t3_release_ready got %b exp 1", bif.req_ready_o);
    end
    e.rdata = 32'hCAFE_0001;
    e.err   = 1'b0;
    sb.push_back(e);
    step();
    bif.req_valid_i = 1'b0;
    #1;
    checks++;
    if (bif.wdata_o !== 32'h55) begin
      failures++;
      $display("FAIL t3_write_data got %h exp 55", bif.wdata_o);
    end
    drain("t3");
  endtask

  task automatic test_error_replay();
    exp_t e;
    bif.ready_i = 1'b1;
    bif.resp_i  = 1'b0;
    bif.rdata_i = 32'h0;
    issue(32'h30, 1'b0, 32'h0, 32'h0, 1'b1);
    bif.req_addr_i  = 32'h34;
    bif.req_write_i = 1'b1;
    bif.req_wdata_i = 32'h77;
    #1;
    checks++;
    if (bif.req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL t4_queue_ready got %b exp 1", bif.req_ready_o);
    end
    e.rdata = '0;
    e.err   = 1'b0;
    sb.push_back(e);
    step();
    bif.req_valid_i = 1'b0;
    bif.ready_i     = 1'b0;
    bif.resp_i      = 1'b1;
    #1;
    checks++;
    if (bif.trans_o !== 1'b1 || bif.req_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL t4_err1 got trans=%b ready=%b exp 1 0", bif.trans_o, bif.req_ready_o);
    end
    step();
    bif.ready_i = 1'b1;
    #1;
    checks++;
    if (bif.trans_o !== 1'b0 || bif.req_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL t4_err2 got trans=%b ready=%b exp 0 0", bif.trans_o, bif.req_ready_o);
    end
    step();
    bif.resp_i = 1'b0;
    #1;
    checks++;
    if (bif.trans_o !== 1'b1 || bif.addr_o !== 32'h34 || bif.write_o !== 1'b1 || bif.wdata_o !== 32'h0) begin
      failures++;
      $display("FAIL t4_replay got trans=%b addr=%h wr=%b wdata=%h exp 1 34 1 0",
               bif.trans_o, bif.addr_o, bif.write_o, bif.wdata_o);
    end
    step();
    checks++;
    if (bif.wdata_o !== 32'h77) begin
      failures++;
      $display("FAIL t4_replay_data got %h exp 77", bif.wdata_o);
    end
    drain("t4");
  endtask

  task automatic test_illegal_resp();
    exp_t e;
    bif.ready_i = 1'b1;
    bif.resp_i  = 1'b0;
    bif.rdata_i = 32'h5050_5050;
    issue(32'h50, 1'b0, 32'h99, 32'h5050_5050, 1'b1);
    bif.req_addr_i  = 32'h54;
    bif.req_write_i = 1'b0;
    bif.req_wdata_i = 32'h0;
    e.rdata = 32'h5050_5050;
    e.err   = 1'b0;
    sb.push_back(e);
    step();
    bif.req_valid_i = 1'b0;
    bif.resp_i      = 1'b1;
    #1;
    checks++;
    if (bif.req_ready_o !== 1'b0 || bif.wdata_o !== 32'h99) begin
      failures++;
      $display("FAIL t5_illegal got ready=%b wdata=%h exp 0 99", bif.req_ready_o, bif.wdata_o);
    end
    step();
    bif.resp_i = 1'b0;
    #1;
    checks++;
    if (bif.trans_o !== 1'b1 || bif.addr_o !== 32'h54 || bif.wdata_o !== 32'h0) begin
      failures++;
      $display("FAIL t5_after_illegal got trans=%b addr=%h wdata=%h exp 1 54 0",
               bif.trans_o, bif.addr_o, bif.wdata_o);
    end
    drain("t5");
  endtask

  task automatic test_default_slave();
    bif.ready_i = 1'b1;
    bif.resp_i  = 1'b0;
    issue(32'hF000_0000, 1'b1, 32'hAB, 32'h0, 1'b1);
    bif.req_valid_i = 1'b0;
    step();
    bif.ready_i = 1'b0;
    bif.resp_i  = 1'b1;
    step();
    bif.ready_i = 1'b1;
    step();
    bif.resp_i  = 1'b0;
    bif.rdata_i = 32'h4040_4040;
    issue(32'h40, 1'b0, 32'h0, 32'h4040_4040, 1'b0);
    drain("t6");
  endtask

  task automatic test_reset_in_flight();
    bif.ready_i = 1'b1;
    bif.resp_i  = 1'b0;
    bif.rdata_i = 32'hA5A5_A5A5;
    issue(32'h5C, 1'b0, 32'h0, 32'hA5A5_A5A5, 1'b0);
    issue(32'h60, 1'b1, 32'h66, 32'h0, 1'b0);
    issue(32'h64, 1'b0, 32'h0, 32'hA5A5_A5A5, 1'b0);
    bif.req_valid_i = 1'b0;
    bif.ready_i     = 1'b0;
    step();
    #2;
    checks++;
    if (bif.wdata_o !== 32'h66 || bif.trans_o !== 1'b1 || bif.rsp_rdata_o !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL t7_pre_reset got wdata=%h trans=%b rdata=%h exp 66 1 a5a5a5a5",
               bif.wdata_o, bif.trans_o, bif.rsp_rdata_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bif.trans_o, bif.write_o, bif.rsp_valid_o, bif.rsp_err_o} !== 4'b0) begin
      failures++;
      $display("FAIL t7_reset_flags got %b exp 0000",
               {bif.trans_o, bif.write_o, bif.rsp_valid_o, bif.rsp_err_o});
    end
    checks++;
    if ({bif.addr_o, bif.wdata_o, bif.rsp_rdata_o} !== 96'h0) begin
      failures++;
      $display("FAIL t7_reset_data got %h exp 0", {bif.addr_o, bif.wdata_o, bif.rsp_rdata_o});
    end
    checks++;
    if (sb.size() != 2) begin
      failures++;
      $display("FAIL t7_in_flight got %0d exp 2", sb.size());
    end
    sb.delete();
    step();
    step();
    rst = 1'b0;
    bif.ready_i = 1'b1;
    repeat (4) step();
    bif.rdata_i = 32'h0000_1234;
    issue(32'h70, 1'b0, 32'h0, 32'h0000_1234, 1'b0);
    drain("t7");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_wait_states();
    test_error_replay();
    test_illegal_resp();
    test_default_slave();
    test_reset_in_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
